// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble binary to packed BCD with saturation on overflow
module bin_to_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  valid_out,
  output logic                  ovf_out
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;
  localparam logic [63:0] MAX_VAL = 64'(10**DIGITS) - 64'd1;
  localparam logic [1:0] IDLE = 2'd0, CONVERT = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [5:0]    cnt;
  logic [SW-1:0] scratch, adj;
  logic          ovf_pend;
  assign ready_out = state == IDLE;
  // add-3 correction on every BCD nibble in parallel before the shift
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS; k++)
      adj[WIDTH+4*k +: 4] = scratch[WIDTH+4*k +: 4] >= 4'd5 ? scratch[WIDTH+4*k +: 4] + 4'd3 : scratch[WIDTH+4*k +: 4];
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      scratch   <= '0;
      ovf_pend  <= 1'b0;
      bcd_out   <= '0;
      valid_out <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE && valid_in) begin
        scratch  <= {{BW{1'b0}}, bin_in};
        ovf_pend <= 64'(bin_in) > MAX_VAL;
        cnt      <= 6'(WIDTH);
        state    <= CONVERT;
      end else if (state == CONVERT) begin
        scratch <= adj << 1;
        cnt     <= cnt - 6'd1;
        if (cnt == 6'd1) state <= DONE;
      end else if (state == DONE) begin
        bcd_out   <= ovf_pend ? {DIGITS{4'h9}} : scratch[SW-1 -: BW];
        ovf_out   <= ovf_pend;
        valid_out <= 1'b1;
        state     <= IDLE;
      end
    end
endmodule
